// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet width, packet field positions, node-ID width
// and the ejector receive-FSM state type.
package noc_pkg;

  localparam int PACKET_WIDTH  = 56;
  localparam int NODE_ID_WIDTH = 6;

  localparam int PKT_ID_MSB    = 25;
  localparam int PKT_ID_LSB    = 16;
  localparam int PKT_SRC_MSB   = 15;
  localparam int PKT_SRC_LSB   = 10;
  localparam int PKT_INFO_MSB  = 9;
  localparam int PKT_INFO_LSB  = 0;

  localparam int PKT_ID_WIDTH  = PKT_ID_MSB - PKT_ID_LSB + 1;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_REL = 1'b1
  } rx_state_t;

endpackage

// File: rtl/noc_local_ejector_if.sv
// Local-port link of the ejector: router req/grant/full handshake plus the
// valid/ready packet stream toward the PE.
interface noc_local_ejector_if #(
  parameter int PACKET_WIDTH = noc_pkg::PACKET_WIDTH
);

  logic                    ReqUpStr;
  logic [PACKET_WIDTH-1:0] PacketIn;
  logic                    GntUpStr;
  logic                    UpStrFull;
  logic                    PktValid;
  logic [PACKET_WIDTH-1:0] PktData;
  logic                    PktReady;

  // slave: the ejector; master: router + PE side driving it
  modport slave (
    input  ReqUpStr, PacketIn, PktReady,
    output GntUpStr, UpStrFull, PktValid, PktData
  );

  modport master (
    output ReqUpStr, PacketIn, PktReady,
    input  GntUpStr, UpStrFull, PktValid, PktData
  );

endinterface

// File: rtl/noc_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered occupancy count.
// Push is ignored when full, pop is ignored when empty.
module noc_sync_fifo #(
  parameter int WIDTH = 56,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("noc_sync_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage is not reset; consumers must qualify head with empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/noc_local_ejector.sv
// PE-side packet sink at a router local output port: one packet per req/grant
// handshake into a FIFO, streamed to the PE. Optional sequence check: NOC_EJECTOR_SEQCHK_EN.
module noc_local_ejector
  import noc_pkg::*;
#(
  parameter logic [NODE_ID_WIDTH-1:0] MODULE_ID    = 6'b001_010,
  parameter int                       PACKET_WIDTH = noc_pkg::PACKET_WIDTH,
  parameter int                       FIFO_DEPTH   = 4,
  parameter int                       CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  noc_local_ejector_if.slave   link,
  output logic [CNT_WIDTH-1:0] RxCount
`ifdef NOC_EJECTOR_SEQCHK_EN
  ,
  output logic [CNT_WIDTH-1:0] SeqErrCount
`endif
);

  if ($bits(MODULE_ID) != NODE_ID_WIDTH) begin : g_bad_id
    $error("noc_local_ejector: MODULE_ID must be a node ID");
  end

  rx_state_t                  state_reg;
  rx_state_t                  state_next;
  logic                       gnt_reg;
  logic                       gnt_next;
  logic                       push;
  logic [CNT_WIDTH-1:0]       rx_count_reg;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [PACKET_WIDTH-1:0]    fifo_head;

  noc_sync_fifo #(
    .WIDTH (PACKET_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (link.PacketIn),
    .pop       (link.PktReady),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // Full is the pre-edge registered value, so a pop in the same cycle does
  // not open space for a grant until the following cycle.
  always_comb begin
    state_next = state_reg;
    gnt_next   = 1'b0;
    push       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (link.ReqUpStr && !fifo_full) begin
          push       = 1'b1;
          gnt_next   = 1'b1;
          state_next = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!link.ReqUpStr) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      gnt_reg      <= 1'b0;
      rx_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      if (push) begin
        rx_count_reg <= rx_count_reg + 1'b1;
      end
    end
  end

  assign link.GntUpStr  = gnt_reg;
  assign link.UpStrFull = fifo_full;
  assign link.PktValid  = (fifo_count != '0);
  assign link.PktData   = fifo_empty ? '0 : fifo_head;
  assign RxCount        = rx_count_reg;

`ifdef NOC_EJECTOR_SEQCHK_EN
  logic [PKT_ID_WIDTH-1:0]  push_id;
  logic [NODE_ID_WIDTH-1:0] push_src;
  logic [PKT_ID_WIDTH-1:0]  exp_id_reg [64];
  logic [CNT_WIDTH-1:0]     seq_err_reg;

  assign push_id  = link.PacketIn[PKT_ID_MSB:PKT_ID_LSB];
  assign push_src = link.PacketIn[PKT_SRC_MSB:PKT_SRC_LSB];

  // One expected-ID register per source; the next ID is learned on every push.
  for (genvar gi = 0; gi < 64; gi++) begin : g_seq
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        exp_id_reg[gi] <= PKT_ID_WIDTH'(1);
      end else if (push && push_src == NODE_ID_WIDTH'(gi)) begin
        exp_id_reg[gi] <= push_id + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_err_reg <= '0;
    end else if (push && push_id != exp_id_reg[push_src]) begin
      seq_err_reg <= seq_err_reg + 1'b1;
    end
  end

  assign SeqErrCount = seq_err_reg;
`endif

endmodule

// File: tb/tb_noc_local_ejector.sv
// Randomized bench for noc_local_ejector against a queue-based transaction model;
// covers backpressure, held requests and reset during the release wait.
module tb_noc_local_ejector;
  import noc_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] rx_count;
`ifdef NOC_EJECTOR_SEQCHK_EN
  logic [CW-1:0] seq_err_count;
`endif

  noc_local_ejector_if #(.PACKET_WIDTH(PACKET_WIDTH)) link ();

  noc_local_ejector #(
    .MODULE_ID    (6'b001_010),
    .PACKET_WIDTH (PACKET_WIDTH),
    .FIFO_DEPTH   (DEPTH),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .link        (link),
    .RxCount     (rx_count)
`ifdef NOC_EJECTOR_SEQCHK_EN
    ,
    .SeqErrCount (seq_err_count)
`endif
  );

  always #5 clk = ~clk;

  int tests    = 0;
  int failures = 0;

  // Reference model: buffered packets, whether the current request was served,
  // and the counters as the rules define them.
  logic [PACKET_WIDTH-1:0] model_q[$];
  logic [PACKET_WIDTH-1:0] directed_q[$];
  bit                      served;
  logic                    exp_gnt;
  logic [CW-1:0]           exp_rx;
  logic [CW-1:0]           exp_seq_err;
  logic [9:0]              exp_seq_id [64];

  bit granted_seen;
  int hold_cnt;
  bit reached;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PACKET_WIDTH-1:0] mk_pkt(input logic [9:0] id, input logic [5:0] src,
                                                      input logic [9:0] info);
    return {{(PACKET_WIDTH-26){1'b0}}, id, src, info};
  endfunction

  task automatic model_reset();
    model_q.delete();
    served      = 1'b0;
    exp_gnt     = 1'b0;
    exp_rx      = '0;
    exp_seq_err = '0;
    for (int i = 0; i < 64; i++) exp_seq_id[i] = 10'd1;
  endtask

  task automatic check_outputs();
    logic [PACKET_WIDTH-1:0] exp_data;
    exp_data = (model_q.size() != 0) ? model_q[0] : '0;
    check("gnt",   64'(link.GntUpStr),  64'(exp_gnt));
    check("valid", 64'(link.PktValid),  64'(model_q.size() != 0));
    check("data",  64'(link.PktData),   64'(exp_data));
    check("full",  64'(link.UpStrFull), 64'(model_q.size() == DEPTH));
    check("rx",    64'(rx_count),       64'(exp_rx));
`ifdef NOC_EJECTOR_SEQCHK_EN
    check("seqerr", 64'(seq_err_count), 64'(exp_seq_err));
`endif
  endtask

  function automatic logic [PACKET_WIDTH-1:0] next_packet();
    logic [5:0] src;
    logic [9:0] id;
    if (directed_q.size() != 0) return directed_q.pop_front();
    src = 6'($urandom_range(0, 3));
    id  = ($urandom_range(0, 3) != 0) ? exp_seq_id[src] : 10'($urandom);
    return mk_pkt(id, src, 10'($urandom));
  endfunction

  // Predict the effect of the coming rising edge from the inputs just driven.
  task automatic model_step();
    int         sz;
    bit         pop;
    bit         acc;
    logic [5:0] src;
    logic [9:0] id;
    sz  = model_q.size();
    pop = link.PktReady && (sz > 0);
    acc = link.ReqUpStr && !served && (sz < DEPTH);
    if (pop) void'(model_q.pop_front());
    if (acc) begin
      model_q.push_back(link.PacketIn);
      exp_rx = exp_rx + 1'b1;
      id  = link.PacketIn[25:16];
      src = link.PacketIn[15:10];
      if (id != exp_seq_id[src]) exp_seq_err = exp_seq_err + 1'b1;
      exp_seq_id[src] = id + 1'b1;
    end
    if (acc)                served = 1'b1;
    else if (!link.ReqUpStr) served = 1'b0;
    exp_gnt = acc;
  endtask

  task automatic run_cycles(input int n, input int ready_pct, input int req_pct, input int hold_max,
                            input bit stop_at_wait3, output bit hit);
    hit = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check_outputs();
      if (link.ReqUpStr) begin
        if (!granted_seen && link.GntUpStr) begin
          granted_seen = 1'b1;
          hold_cnt     = int'($urandom_range(0, hold_max));
        end
        if (granted_seen) begin
          if (hold_cnt == 0) begin
            link.ReqUpStr = 1'b0;
            granted_seen  = 1'b0;
          end else begin
            hold_cnt--;
          end
        end
      end else if (int'($urandom_range(0, 99)) < req_pct) begin
        link.PacketIn = next_packet();
        link.ReqUpStr = 1'b1;
      end
      link.PktReady = (int'($urandom_range(0, 99)) < ready_pct);
      model_step();
      if (stop_at_wait3 && model_q.size() == 3 && exp_gnt) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    link.ReqUpStr = 1'b0;
    link.PacketIn = '0;
    link.PktReady = 1'b0;
    granted_seen  = 1'b0;
    hold_cnt      = 0;
    model_reset();

    directed_q.push_back({{(PACKET_WIDTH-26){1'b0}}, 26'h0041_0A00});
    directed_q.push_back(mk_pkt(10'd1, 6'b001_010, 10'h011));
    directed_q.push_back(mk_pkt(10'd2, 6'b001_010, 10'h022));
    directed_q.push_back(mk_pkt(10'd4, 6'b001_010, 10'h044));
    directed_q.push_back(mk_pkt(10'd5, 6'b001_010, 10'h055));
    directed_q.push_back(mk_pkt(10'd1, 6'b000_001, 10'h101));

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs();
    reset = 1'b0;

    run_cycles(300, 50, 70, 2, 1'b0, reached);
    run_cycles(300, 10, 90, 3, 1'b0, reached);
    run_cycles(300, 90, 60, 2, 1'b0, reached);
    run_cycles(30, 100, 0, 0, 1'b0, reached);

    // Fill three entries with the PE stalled, then reset while the third
    // request is still held in the release wait.
    run_cycles(50, 0, 100, 2, 1'b1, reached);
    check("wait_rel_reached", 64'(reached), 64'(1));
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    link.ReqUpStr = 1'b0;
    link.PktReady = 1'b0;
    granted_seen  = 1'b0;
    @(negedge clk);
    check_outputs();
    reset = 1'b0;

    run_cycles(200, 60, 70, 2, 1'b0, reached);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
